// File: rtl/cpu_pkg.sv
// Shared pipeline-control types for the 8-bit CPU: register address width,
// EX operand forwarding encodings and the hazard scoreboard entry layout.
package cpu_pkg;

  localparam int unsigned REG_AW = 4;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] waddr;
    logic              is_load;
  } sb_entry_t;

  // Operand sources kept alongside the EX entry so forwarding can be resolved in EX
  typedef struct packed {
    logic [REG_AW-1:0] a_addr;
    logic [REG_AW-1:0] b_addr;
    logic              uses_a;
    logic              uses_b;
  } sb_src_t;

  // MEM wins over WB; a load still in MEM has no data yet and cannot forward
  function automatic logic [1:0] fwd_select(input logic mem_hit, input logic mem_load,
                                            input logic wb_hit);
    if (mem_hit && !mem_load) return FWD_MEM;
    if (wb_hit) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/id_hazard_ctrl_if.sv
// ID-side hazard bus: decode-stage operand/destination info toward the hazard
// controller, pipeline stall/flush/bubble controls and EX forwarding selects back.
interface id_hazard_ctrl_if;
  import cpu_pkg::*;

  logic [REG_AW-1:0] A_address_ID;
  logic [REG_AW-1:0] B_address_ID;
  logic [REG_AW-1:0] W_address_ID;
  logic              uses_A_ID;
  logic              uses_B_ID;
  logic              reg_write_ID;
  logic              mem_read_ID;
  logic              branch_taken_EX;

  logic              stall_PC;
  logic              stall_IFID;
  logic              flush_IFID;
  logic              bubble_IDEXE;
  logic [1:0]        fwdA_sel;
  logic [1:0]        fwdB_sel;

  modport master (
    output A_address_ID, B_address_ID, W_address_ID, uses_A_ID, uses_B_ID,
           reg_write_ID, mem_read_ID, branch_taken_EX,
    input  stall_PC, stall_IFID, flush_IFID, bubble_IDEXE, fwdA_sel, fwdB_sel
  );

  modport slave (
    input  A_address_ID, B_address_ID, W_address_ID, uses_A_ID, uses_B_ID,
           reg_write_ID, mem_read_ID, branch_taken_EX,
    output stall_PC, stall_IFID, flush_IFID, bubble_IDEXE, fwdA_sel, fwdB_sel
  );

endinterface

// File: rtl/sb_match.sv
// One scoreboard entry versus one operand source; register 0 never matches.
module sb_match
  import cpu_pkg::*;
(
  input  logic              valid,
  input  logic [REG_AW-1:0] waddr,
  input  logic [REG_AW-1:0] src,
  input  logic              uses,
  output logic              match_c
);

  assign match_c = valid && uses && (src != '0) && (waddr == src);

endmodule

// File: rtl/id_hazard_ctrl.sv
// Hazard detection and forwarding control beside ID; EX/MEM/WB destination scoreboard on the falling edge.
// HAZARD_FORWARD_EN: forwarding plus 1-cycle load-use stall; undefined: stall until the producer retires.
module id_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  id_hazard_ctrl_if.slave  bus,
  output logic [CNT_W-1:0] stall_count
);

  sb_entry_t ex_q, mem_q, wb_q;
  sb_src_t   ex_src_q;

  logic       hazard;
  logic [1:0] fwd_a, fwd_b;
  logic       stall, flush, bubble;
  logic [1:0] sel_a, sel_b;

  // ID operands against the EX entry, needed by both build flavours
  logic id_a_ex, id_b_ex;

  sb_match u_id_a_ex (.valid(ex_q.valid), .waddr(ex_q.waddr), .src(bus.A_address_ID),
                      .uses(bus.uses_A_ID), .match_c(id_a_ex));
  sb_match u_id_b_ex (.valid(ex_q.valid), .waddr(ex_q.waddr), .src(bus.B_address_ID),
                      .uses(bus.uses_B_ID), .match_c(id_b_ex));

`ifdef HAZARD_FORWARD_EN
  // EX-stage operands (stored at issue) against the MEM and WB producers
  logic ex_a_mem, ex_b_mem, ex_a_wb, ex_b_wb;
  logic unused_ok;

  sb_match u_ex_a_mem (.valid(mem_q.valid), .waddr(mem_q.waddr), .src(ex_src_q.a_addr),
                       .uses(ex_src_q.uses_a), .match_c(ex_a_mem));
  sb_match u_ex_b_mem (.valid(mem_q.valid), .waddr(mem_q.waddr), .src(ex_src_q.b_addr),
                       .uses(ex_src_q.uses_b), .match_c(ex_b_mem));
  sb_match u_ex_a_wb  (.valid(wb_q.valid), .waddr(wb_q.waddr), .src(ex_src_q.a_addr),
                       .uses(ex_src_q.uses_a), .match_c(ex_a_wb));
  sb_match u_ex_b_wb  (.valid(wb_q.valid), .waddr(wb_q.waddr), .src(ex_src_q.b_addr),
                       .uses(ex_src_q.uses_b), .match_c(ex_b_wb));

  assign hazard    = (id_a_ex || id_b_ex) && ex_q.is_load;
  assign fwd_a     = fwd_select(ex_a_mem, mem_q.is_load, ex_a_wb);
  assign fwd_b     = fwd_select(ex_b_mem, mem_q.is_load, ex_b_wb);
  assign unused_ok = wb_q.is_load;
`else
  // No bypass network: any in-flight producer of an ID operand holds ID
  logic id_a_mem, id_b_mem, id_a_wb, id_b_wb;
  logic unused_ok;

  sb_match u_id_a_mem (.valid(mem_q.valid), .waddr(mem_q.waddr), .src(bus.A_address_ID),
                       .uses(bus.uses_A_ID), .match_c(id_a_mem));
  sb_match u_id_b_mem (.valid(mem_q.valid), .waddr(mem_q.waddr), .src(bus.B_address_ID),
                       .uses(bus.uses_B_ID), .match_c(id_b_mem));
  sb_match u_id_a_wb  (.valid(wb_q.valid), .waddr(wb_q.waddr), .src(bus.A_address_ID),
                       .uses(bus.uses_A_ID), .match_c(id_a_wb));
  sb_match u_id_b_wb  (.valid(wb_q.valid), .waddr(wb_q.waddr), .src(bus.B_address_ID),
                       .uses(bus.uses_B_ID), .match_c(id_b_wb));

  assign hazard    = id_a_ex || id_b_ex || id_a_mem || id_b_mem || id_a_wb || id_b_wb;
  assign fwd_a     = FWD_RF;
  assign fwd_b     = FWD_RF;
  assign unused_ok = ^{ex_q.is_load, mem_q.is_load, wb_q.is_load, ex_src_q};
`endif

  // Branch redirect overrides any stall; reset silences every control
  always_comb begin
    stall  = 1'b0;
    flush  = 1'b0;
    bubble = 1'b0;
    sel_a  = FWD_RF;
    sel_b  = FWD_RF;
    if (!rst) begin
      if (bus.branch_taken_EX) begin
        flush  = 1'b1;
        bubble = 1'b1;
      end else if (hazard) begin
        stall  = 1'b1;
        bubble = 1'b1;
      end
      sel_a = fwd_a;
      sel_b = fwd_b;
    end
  end

  assign bus.stall_PC     = stall;
  assign bus.stall_IFID   = stall;
  assign bus.flush_IFID   = flush;
  assign bus.bubble_IDEXE = bubble;
  assign bus.fwdA_sel     = sel_a;
  assign bus.fwdB_sel     = sel_b;

  // Scoreboard advances with the pipeline registers; a bubble enters EX as invalid
  always_ff @(negedge clk) begin
    if (rst) begin
      ex_q     <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
      ex_src_q <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (bubble) begin
        ex_q     <= '0;
        ex_src_q <= '0;
      end else begin
        ex_q     <= '{valid: bus.reg_write_ID, waddr: bus.W_address_ID, is_load: bus.mem_read_ID};
        ex_src_q <= '{a_addr: bus.A_address_ID, b_addr: bus.B_address_ID,
                      uses_a: bus.uses_A_ID, uses_b: bus.uses_B_ID};
      end
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule
